// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the SRAM arbiter: FSM state encoding,
// timing defaults and SRAM bus widths.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VRD,
        CRD,
        CWR,
        CACK
    } arb_state_t;

    localparam int unsigned RD_CYC_DEF  = 2;
    localparam int unsigned WR_CYC_DEF  = 2;
    localparam int unsigned VID_MAX_DEF = 4;

    localparam int unsigned ADR_W = 18;
    localparam int unsigned DAT_W = 32;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous 32-bit SRAM between the video fetch engine
// (priority) and the CPU load/store port, with bounded CPU starvation.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned RD_CYC  = RD_CYC_DEF,
    parameter int unsigned WR_CYC  = WR_CYC_DEF,
    parameter int unsigned VID_MAX = VID_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vid_req,
    input  logic [ADR_W-1:0]     vid_adr,
    output logic [DAT_W-1:0]     vid_data,
    output logic                 vid_ack,
    output logic                 vid_ovr,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [ADR_W-1:0]     cpu_adr,
    input  logic [3:0]           cpu_ben,
    input  logic [DAT_W-1:0]     cpu_wdata,
    output logic [DAT_W-1:0]     cpu_rdata,
    output logic                 cpu_stall,
    output logic [ADR_W-1:0]     sram_adr,
    output logic [DAT_W-1:0]     sram_dout,
    output logic                 sram_drive,
    input  logic [DAT_W-1:0]     sram_din,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [3:0]           sram_be_n
);

    localparam logic [2:0] RD_LAST = 3'(RD_CYC - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_CYC - 1);
    localparam logic [3:0] STARVE_MAX = 4'(VID_MAX);

    arb_state_t  state;
    logic [2:0]  cnt;
    logic [3:0]  starve;
    logic        vid_pend;
    logic        cpu_req;
    logic        vid_win;

    always_comb begin
        cpu_req   = cpu_rd | cpu_wr;
        vid_win   = (state == IDLE) && vid_pend && !(cpu_req && (starve == STARVE_MAX));
        cpu_stall = cpu_req && (state != CACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve     <= '0;
            vid_pend   <= 1'b0;
            vid_ovr    <= 1'b0;
            vid_ack    <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
            sram_adr   <= '0;
            sram_dout  <= '0;
            sram_drive <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
        end else begin
            vid_ack <= 1'b0;

            // A request landing on the grant edge is a new fetch and stays
            // pending; only a request folded into an existing one is an overrun.
            if (vid_win) begin
                vid_pend <= vid_req;
            end else if (vid_req) begin
                vid_pend <= 1'b1;
                if (vid_pend) begin
                    vid_ovr <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (vid_win) begin
                        state     <= VRD;
                        sram_adr  <= vid_adr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= '0;
                        if (cpu_req) begin
                            starve <= (starve < STARVE_MAX) ? starve + 4'd1 : starve;
                        end else begin
                            starve <= '0;
                        end
                    end else if (cpu_wr) begin
                        state      <= CWR;
                        starve     <= '0;
                        sram_adr   <= cpu_adr;
                        sram_dout  <= cpu_wdata;
                        sram_be_n  <= ~cpu_ben;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b0;
                        sram_drive <= 1'b1;
                    end else if (cpu_rd) begin
                        state     <= CRD;
                        starve    <= '0;
                        sram_adr  <= cpu_adr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= '0;
                    end else begin
                        starve <= '0;
                    end
                end

                VRD, CRD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == RD_LAST) begin
                        cnt       <= '0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                        if (state == VRD) begin
                            vid_data <= sram_din;
                            vid_ack  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cpu_rdata <= sram_din;
                            state     <= CACK;
                        end
                    end
                end

                CWR: begin
                    cnt <= cnt + 3'd1;
                    // sram_drive stays high into CACK to hold data past we_n rise
                    if (cnt == WR_LAST) begin
                        cnt       <= '0;
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_be_n <= '1;
                        state     <= CACK;
                    end
                end

                CACK: begin
                    sram_drive <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
